// File: rtl/spi_rx_master_pkg.sv
// Shared constants and FSM state encoding for the SPI readout initiator.
package spi_rx_master_pkg;

  localparam int SPI_WORD_W      = 27;
  localparam int SPI_CLK_DIV_MIN = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SETUP = 3'd2,
    ST_HIGH  = 3'd3,
    ST_LOW   = 3'd4,
    ST_TAIL  = 3'd5,
    ST_GAP   = 3'd6
  } spi_state_e;

endpackage

// File: rtl/spi_rx_master_phase_cnt.sv
// Phase timer: down-counter reloaded on every state entry, done on terminal count.
module spi_rx_master_phase_cnt
  import spi_rx_master_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // A reload on entry makes the phase last exactly CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/spi_rx_master.sv
// SPI initiator reading one WIDTH-bit word MSB first from the shift-out port.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | one-cycle load pulse to the port, cs_n high
//   SETUP | cs_n low, sclk low before the first rise
//   HIGH  | sclk high; bit captured on entry
//   LOW   | sclk low; port shifts its next bit out
//   TAIL  | sclk low hold after the last fall
//   GAP   | cs_n high minimum deselect time
module spi_rx_master
  import spi_rx_master_pkg::*;
#(
  parameter int WIDTH   = SPI_WORD_W,
  parameter int CLK_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             load,
  output logic             cs_n,
  output logic             sclk,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  spi_state_e       state;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg;
  logic             phase_done;
  logic             phase_restart;

  // Holding the timer in reload while IDLE/LOAD gives SETUP a full phase.
  assign phase_restart = phase_done || (state == ST_IDLE) || (state == ST_LOAD);

  spi_rx_master_phase_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_cnt (
    .clk     (clk),
    .rst     (rst),
    .restart (phase_restart),
    .done    (phase_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      load     <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      valid    <= 1'b0;
      data_out <= '0;
      sreg     <= '0;
      bit_cnt  <= '0;
    end else begin
      load  <= 1'b0;
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
            load  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          state   <= ST_SETUP;
          cs_n    <= 1'b0;
          bit_cnt <= '0;
          sreg    <= '0;
        end
        ST_SETUP: begin
          if (phase_done) begin
            state <= ST_HIGH;
            sclk  <= 1'b1;
            sreg  <= {sreg[WIDTH-2:0], serial_in};
          end
        end
        ST_HIGH: begin
          if (phase_done) begin
            sclk  <= 1'b0;
            state <= (bit_cnt == LAST_BIT) ? ST_TAIL : ST_LOW;
          end
        end
        ST_LOW: begin
          if (phase_done) begin
            state   <= ST_HIGH;
            sclk    <= 1'b1;
            bit_cnt <= bit_cnt + BW'(1);
            sreg    <= {sreg[WIDTH-2:0], serial_in};
          end
        end
        ST_TAIL: begin
          if (phase_done) begin
            state    <= ST_GAP;
            cs_n     <= 1'b1;
            data_out <= sreg;
            valid    <= 1'b1;
          end
        end
        ST_GAP: begin
          if (phase_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          cs_n  <= 1'b1;
          sclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule
